keypad_scanner: RTL

- Scans a 4x4 matrix keypad, debounces presses and releases, and emits one 8-bit key code per press.
- Produces the key-code stream the calculator FSM consumes as its `in` bus; its `key_code` output connects there directly.
- Idle value is all-ones, so the consumer's `&in` "no key" test works unchanged.
- Digits 0–9 arrive as their BCD value in bits [3:0].

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_scanner_sync2.sv | 21 ++
 rtl/keypad_scanner.sv | 83 ++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, scanner state encoding and the row/column keymap.
package keypad_pkg;

    localparam logic [7:0] KEY_NONE = 8'hFF;
    localparam logic [7:0] KEY_ADD  = 8'h0A;
    localparam logic [7:0] KEY_SUB  = 8'h0B;
    localparam logic [7:0] KEY_MUL  = 8'h0C;
    localparam logic [7:0] KEY_DIV  = 8'h0D;
    localparam logic [7:0] KEY_EQ   = 8'h0E;
    localparam logic [7:0] KEY_CLR  = 8'h0F;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_e;

    // Entry {row, col} lives at byte index 4*row + col, row0/col0 in the LSB.
    localparam logic [127:0] KEYMAP = {
        KEY_DIV, KEY_EQ, 8'h00, KEY_CLR,
        KEY_MUL, 8'h09, 8'h08, 8'h07,
        KEY_SUB, 8'h06, 8'h05, 8'h04,
        KEY_ADD, 8'h03, 8'h02, 8'h01
    };

    function automatic logic [1:0] onecold_idx(input logic [3:0] v);
        return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [7:0] keymap(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[8 * int'({row, col}) +: 8];
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: parameterized-width two-flop synchronizer, resets to all ones (keys released).
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '1;
            q_o  <= '1;
        end else begin
            s1_q <= d_i;
            q_o  <= s1_q;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces press and release,
// and emits one registered key code plus a single-cycle valid per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [7:0] key_code,
    output logic       key_valid
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYC);
    localparam logic [3:0] ROW_FIRST = 4'b1110;

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] deb_q, deb_d;
    logic [3:0]    row_q, row_d, pat_q, pat_d, cs;
    logic [7:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          dwell_end, deb_end, one_low, all_hi, match, stay;

    sync2 #(.W(4)) u_sync (.clk(clk), .rst(rst), .d_i(col_n), .q_o(cs));

    assign dwell_end = dwell_q == DW'(SCAN_DIV - 1);
    assign deb_end   = deb_q == BW'(DEBOUNCE_CYC - 1);
    assign one_low   = $countones(~cs) == 1;
    assign all_hi    = &cs;
    assign match     = cs == pat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            dwell_q <= '0;
            deb_q   <= '0;
            row_q   <= ROW_FIRST;
            pat_q   <= '1;
            code_q  <= KEY_NONE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:      state_d = (dwell_end && one_low) ? DEB_PRESS : SCAN;
            DEB_PRESS: state_d = !match ? SCAN : deb_end ? PRESSED : DEB_PRESS;
            PRESSED:   state_d = all_hi ? DEB_REL : PRESSED;
            default:   state_d = !all_hi ? PRESSED : deb_end ? SCAN : DEB_REL;
        endcase
    end

    // Counters clear on any state change, so they never need to wrap.
    always_comb begin
        stay    = state_d == state_q;
        valid_d = state_q == DEB_PRESS && state_d == PRESSED;
        dwell_d = (state_q == SCAN && stay && !dwell_end) ? dwell_q + 1'b1 : '0;
        deb_d   = (stay && (state_q == DEB_PRESS || state_q == DEB_REL)) ? deb_q + 1'b1 : '0;
        pat_d   = (state_q == SCAN && !stay) ? cs : pat_q;
        row_d   = (state_q == DEB_REL && state_d == SCAN) ? ROW_FIRST :
                  ((state_q == SCAN && stay && dwell_end) ||
                   (state_q == DEB_PRESS && state_d == SCAN)) ? {row_q[2:0], row_q[3]} : row_q;
        code_d  = valid_d ? keymap(onecold_idx(row_q), onecold_idx(pat_q)) :
                  (state_q == DEB_REL && state_d == SCAN) ? KEY_NONE : code_q;
    end

    assign row_n     = row_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
endmodule
